uart_pkt_ctrl: RTL and testbench

- Packet sequencer between the UART RX/TX byte streams and the 32-bit ALU.
- Parses framed command packets from the host: opcode, reserved byte, 16-bit little-endian total length (the length includes the 4 header bytes), then payload.
- Either echoes the payload back, or folds the 32-bit operands through the ALU and returns the 4-byte result.
- Owns the ALU start/done handshake. This block is the only ALU requester.

---
 rtl/uart_pkt_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_pkt_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pkt_ctrl.sv
// uart_pkt_ctrl: framed UART command sequencer (echo / ALU fold) in front of the ALU.
// Define PKT_TIMEOUT_EN to add an inter-byte idle timeout of TIMEOUT_CYCLES.
module uart_pkt_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [1:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_start_o,
  input  logic        alu_done_i,
  input  logic [31:0] alu_result_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [3:0] {
    IDLE, RSVD, LEN_LO, LEN_HI, ECHO,
    LOAD_A, LOAD_B, WAIT, SEND, DRAIN
  } state_e;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  state_e      state_q, state_d;
  logic [7:0]  opc_q, len_lo_q;
  logic [15:0] rem_q;
  logic [31:0] acc_q, opb_q;
  logic [1:0]  cnt_q;
  logic        err_q, err_d, start_q;
  logic        rx_hs, tx_hs, last, tmo;
  logic        is_echo, is_arith;
  logic [15:0] len, len_m4;

  assign is_echo  = opc_q == OP_ECHO;
  assign is_arith = opc_q inside {OP_ADD, OP_MUL, OP_DIV};
  assign len      = {rx_data_i, len_lo_q};
  assign len_m4   = len - 16'd4;
  assign last     = rem_q == 16'd1;
  assign rx_hs    = rx_valid_i & rx_ready_o;
  assign tx_hs    = tx_valid_o & tx_ready_i;

  assign alu_a_o     = acc_q;
  assign alu_b_o     = opb_q;
  assign alu_op_o    = opc_q[1:0];
  assign alu_start_o = start_q;
  assign busy_o      = state_q != IDLE;
  assign err_o       = err_q;

  // IDLE ready is held low while reset is asserted
  always_comb begin
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    unique case (state_q)
      IDLE: rx_ready_o = rst_ni;
      RSVD, LEN_LO, LEN_HI,
      LOAD_A, LOAD_B, DRAIN: rx_ready_o = 1'b1;
      ECHO: begin
        rx_ready_o = tx_ready_i;
        tx_valid_o = rx_valid_i;
        tx_data_o  = rx_data_i;
      end
      SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = acc_q[{cnt_q, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE:   if (rx_hs) state_d = RSVD;
      RSVD:   if (rx_hs) state_d = LEN_LO;
      LEN_LO: if (rx_hs) state_d = LEN_HI;
      LEN_HI: if (rx_hs) begin
        if (len < 16'd4) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (is_echo) begin
          state_d = (len_m4 == 16'd0) ? IDLE : ECHO;
        end else if (is_arith && len_m4 != 16'd0
                     && len_m4[1:0] == 2'd0) begin
          state_d = LOAD_A;
        end else begin
          err_d   = 1'b1;
          state_d = (len_m4 == 16'd0) ? IDLE : DRAIN;
        end
      end
      ECHO, DRAIN: if (rx_hs && last) state_d = IDLE;
      LOAD_A: if (rx_hs && cnt_q == 2'd3)
        state_d = last ? SEND : LOAD_B;
      LOAD_B: if (rx_hs && cnt_q == 2'd3) state_d = WAIT;
      WAIT: if (alu_done_i)
        state_d = (rem_q == 16'd0) ? SEND : LOAD_B;
      SEND: if (tx_hs && cnt_q == 2'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      opc_q    <= 8'h00;
      len_lo_q <= 8'h00;
      rem_q    <= 16'd0;
      acc_q    <= 32'd0;
      opb_q    <= 32'd0;
      cnt_q    <= 2'd0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      start_q <= (state_q == LOAD_B) && rx_hs && (cnt_q == 2'd3);
      unique case (state_q)
        IDLE: begin
          cnt_q <= 2'd0;
          if (rx_hs) opc_q <= rx_data_i;
        end
        LEN_LO: if (rx_hs) len_lo_q <= rx_data_i;
        LEN_HI: if (rx_hs) rem_q <= len_m4;
        ECHO, DRAIN: if (rx_hs) rem_q <= rem_q - 16'd1;
        LOAD_A: if (rx_hs) begin
          acc_q[{cnt_q, 3'b000} +: 8] <= rx_data_i;
          rem_q <= rem_q - 16'd1;
          cnt_q <= cnt_q + 2'd1;
        end
        LOAD_B: if (rx_hs) begin
          opb_q[{cnt_q, 3'b000} +: 8] <= rx_data_i;
          rem_q <= rem_q - 16'd1;
          cnt_q <= cnt_q + 2'd1;
        end
        WAIT: if (alu_done_i) acc_q <= alu_result_i;
        SEND: if (tx_hs) cnt_q <= cnt_q + 2'd1;
        default: ;
      endcase
    end
  end

`ifdef PKT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          tmo_st;

  assign tmo_st = state_q inside {RSVD, LEN_LO, LEN_HI,
                                  LOAD_A, LOAD_B, ECHO, DRAIN};
  assign tmo = tmo_st && !rx_hs
               && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      tmo_q <= '0;
    else if (!tmo_st || rx_hs || state_d != state_q)
      tmo_q <= '0;
    else
      tmo_q <= tmo_q + TW'(1);
  end
`else
  // no timeout; a stalled packet waits forever
  assign tmo = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// tb_uart_pkt_ctrl: directed + randomized packets checked against a packet-level model.
// Define PKT_TIMEOUT_EN to also exercise the idle timeout (TIMEOUT_CYCLES=200).
`timescale 1ns/1ps
module tb_uart_pkt_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [1:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic        alu_start_o;
  logic        alu_done_i;
  logic [31:0] alu_result_i;
  logic        busy_o, err_o;

  uart_pkt_ctrl #(.TIMEOUT_CYCLES(200)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_start_o(alu_start_o), .alu_done_i(alu_done_i),
    .alu_result_i(alu_result_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  pkt[$];
  logic [7:0]  obs_tx[$], exp_tx[$];
  logic [31:0] obs_a[$], obs_b[$], exp_a[$], exp_b[$];
  logic [1:0]  obs_op[$], exp_op[$];
  int          obs_err, exp_err;
  bit          rnd_gap = 0, rnd_rdy = 0, tx_manual = 0;
  int          alu_lat = 5;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_fn(logic [1:0] op,
                                         logic [31:0] a,
                                         logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a * b;
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] word_at(int i);
    return {pkt[i+3], pkt[i+2], pkt[i+1], pkt[i]};
  endfunction

  // packet-level reference: expected TX bytes, ALU requests, error pulses
  task automatic model();
    logic [7:0]  op;
    logic [31:0] acc, b;
    int          len, rem;
    exp_tx.delete(); exp_a.delete(); exp_b.delete(); exp_op.delete();
    exp_err = 0;
    op  = pkt[0];
    len = {pkt[3], pkt[2]};
    if (len < 4) begin
      exp_err = 1;
      return;
    end
    rem = len - 4;
    if (op == 8'hEC) begin
      for (int i = 0; i < rem; i++) exp_tx.push_back(pkt[4+i]);
    end else if (op inside {8'hA0, 8'hA1, 8'hA2}
                 && rem > 0 && rem % 4 == 0) begin
      acc = word_at(4);
      for (int k = 1; k < rem / 4; k++) begin
        b = word_at(4 + 4*k);
        exp_a.push_back(acc);
        exp_b.push_back(b);
        exp_op.push_back(op[1:0]);
        acc = alu_fn(op[1:0], acc, b);
      end
      for (int i = 0; i < 4; i++) exp_tx.push_back(acc[8*i +: 8]);
    end else begin
      exp_err = 1;
    end
  endtask

  // observers sample mid-cycle
  initial forever begin
    @(negedge clk_i);
    if (rst_ni) begin
      if (tx_valid_o && tx_ready_i) obs_tx.push_back(tx_data_o);
      if (err_o) obs_err++;
    end
  end

  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(posedge clk_i); #1;
      if (!tx_manual)
        tx_ready_i = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    logic [31:0] res;
    int          lat;
    alu_done_i   = 1'b0;
    alu_result_i = 32'd0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && alu_start_o) begin
        obs_a.push_back(alu_a_o);
        obs_b.push_back(alu_b_o);
        obs_op.push_back(alu_op_o);
        res = alu_fn(alu_op_o, alu_a_o, alu_b_o);
        lat = (alu_lat != 0) ? alu_lat : $urandom_range(1, 6);
        repeat (lat) @(posedge clk_i);
        #1;
        alu_done_i   = 1'b1;
        alu_result_i = res;
        @(posedge clk_i); #1;
        alu_done_i   = 1'b0;
        alu_result_i = $urandom;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    if (rnd_gap)
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(negedge clk_i);
      ok = rx_ready_o;
      @(posedge clk_i); #1;
    end
    rx_valid_i = 1'b0;
    rx_data_i  = $urandom;
  endtask

  task automatic clear_obs();
    obs_tx.delete(); obs_a.delete(); obs_b.delete(); obs_op.delete();
    obs_err = 0;
  endtask

  task automatic run_pkt(string tag, bit stall);
    bit          ok, stable;
    int          n;
    logic [7:0]  hold;
    clear_obs();
    model();
    if (stall) begin
      tx_manual  = 1'b1;
      tx_ready_i = 1'b0;
    end
    foreach (pkt[i]) begin
      send_byte(pkt[i], ok);
      if (!ok) begin
        chk({tag, "_rx_accept"}, 0, 1);
        break;
      end
    end
    if (stall) begin
      n = 0;
      while (!tx_valid_o && n < 5000) begin @(posedge clk_i); #1; n++; end
      chk({tag, "_send_valid"}, tx_valid_o, 1);
      tx_ready_i = 1'b1;
      @(posedge clk_i); #1;
      tx_ready_i = 1'b0;
      hold   = tx_data_o;
      stable = 1'b1;
      repeat (50) begin
        @(negedge clk_i);
        stable &= tx_valid_o && (tx_data_o == hold);
      end
      chk({tag, "_send_hold"}, stable, 1);
      tx_manual = 1'b0;
    end
    n = 0;
    while (busy_o && n < 5000) begin @(posedge clk_i); #1; n++; end
    chk({tag, "_idle"}, busy_o, 0);
    repeat (2) begin @(posedge clk_i); #1; end
    chk({tag, "_ntx"}, obs_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
      chk({tag, "_tx"}, obs_tx[i], exp_tx[i]);
    chk({tag, "_err"}, obs_err, exp_err);
    chk({tag, "_nstart"}, obs_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      chk({tag, "_a"}, obs_a[i], exp_a[i]);
      chk({tag, "_b"}, obs_b[i], exp_b[i]);
      chk({tag, "_op"}, obs_op[i], exp_op[i]);
    end
  endtask

  task automatic set_pkt(input logic [7:0] op, input int len);
    pkt.delete();
    pkt.push_back(op);
    pkt.push_back(8'($urandom));
    pkt.push_back(len[7:0]);
    pkt.push_back(len[15:8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) pkt.push_back(w[8*i +: 8]);
  endtask

  task automatic check_ctl_zero(string tag);
    chk({tag, "_ctl"}, {busy_o, err_o, rx_ready_o, tx_valid_o,
                        alu_start_o, alu_op_o}, 0);
    chk({tag, "_tx"}, tx_data_o, 0);
    chk({tag, "_a"}, alu_a_o, 0);
    chk({tag, "_b"}, alu_b_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit          ok;
    int          kind, rem, k, n;
    logic [7:0]  op;
    logic [31:0] w;

    rst_ni     = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    check_ctl_zero("reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("idle_ready", rx_ready_o, 1);

    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48, 8'h69};
    run_pkt("echo", 0);
    chk("echo_bytes", {obs_tx[1], obs_tx[0]}, 32'h6948);

    pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
            8'h02, 8'h00, 8'h00, 8'h00};
    run_pkt("add", 0);
    chk("add_res", {obs_tx[3], obs_tx[2], obs_tx[1], obs_tx[0]}, 32'd3);

    set_pkt(8'hA1, 16);
    push_word(32'd3); push_word(32'd4); push_word(32'd5);
    run_pkt("mul", 1);
    chk("mul_res", {obs_tx[3], obs_tx[2], obs_tx[1], obs_tx[0]}, 32'h3C);

    pkt = '{8'h55, 8'h00, 8'h07, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    run_pkt("unk", 0);
    pkt = '{8'hA0, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
    run_pkt("badlen", 0);
    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h12, 8'h34};
    run_pkt("echo2", 0);

    pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 6; i++) send_byte(pkt[i], ok);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_ctl_zero("midrst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
    run_pkt("postrst", 0);
    chk("postrst_byte", obs_tx[0], 32'h7E);

`ifdef PKT_TIMEOUT_EN
    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h48};
    for (int i = 0; i < 5; i++) send_byte(pkt[i], ok);
    n = 0;
    while (!err_o && n < 400) begin @(posedge clk_i); #1; n++; end
    chk("tmo_cycle", n, 200);
    chk("tmo_busy", busy_o, 0);
    repeat (2) begin @(posedge clk_i); #1; end
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
    run_pkt("post_tmo", 0);
`endif

    rnd_gap = 1;
    rnd_rdy = 1;
    alu_lat = 0;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin
          rem = $urandom_range(0, 8);
          set_pkt(8'hEC, rem + 4);
          repeat (rem) pkt.push_back(8'($urandom));
        end
        1: begin
          k  = $urandom_range(1, 4);
          op = 8'hA0 + 8'($urandom_range(0, 2));
          set_pkt(op, 4*k + 4);
          for (int j = 0; j < k; j++) begin
            w = $urandom;
            if (op == 8'hA2 && j > 0) w = $urandom_range(0, 300);
            push_word(w);
          end
        end
        2: begin
          op = 8'($urandom);
          while (op inside {8'hEC, 8'hA0, 8'hA1, 8'hA2}) op = 8'($urandom);
          rem = $urandom_range(0, 6);
          set_pkt(op, rem + 4);
          repeat (rem) pkt.push_back(8'($urandom));
        end
        3: begin
          rem = $urandom_range(1, 7);
          if (rem == 4) rem = 0;
          set_pkt(8'hA0 + 8'($urandom_range(0, 2)), rem + 4);
          repeat (rem) pkt.push_back(8'($urandom));
        end
        default: begin
          set_pkt(8'($urandom), $urandom_range(0, 3));
        end
      endcase
      run_pkt("rand", 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
